// File: rtl/pes_seqgen_if.sv
// Bundles the pes_seqgen request inputs and serial outputs.
// The master side drives requests and the slave side (the transmitter) drives the line.
interface pes_seqgen_if #(
   parameter int PAT_W = 5,
   parameter int CNT_W = 4,
   parameter int GAP_W = 4
) ();
   logic             start;
   logic [PAT_W-1:0] pattern_in;
   logic [CNT_W-1:0] repeat_cnt;
   logic [GAP_W-1:0] gap_len;
   logic             sequence_out;
   logic             valid_out;
   logic             busy;
   logic             done;

   modport master (
      output start, pattern_in, repeat_cnt, gap_len,
      input  sequence_out, valid_out, busy, done
   );

   modport slave (
      input  start, pattern_in, repeat_cnt, gap_len,
      output sequence_out, valid_out, busy, done
   );
endinterface

// File: rtl/pes_seqgen.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeated with optional gaps.
// Define SEQGEN_PARITY_EN to append an even-parity bit after every frame.
module pes_seqgen #(
   parameter int PAT_W = 5,
   parameter int CNT_W = 4,
   parameter int GAP_W = 4
) (
   input  logic        clock,
   input  logic        reset,
   pes_seqgen_if.slave bus
);
   localparam int BCW = $clog2(PAT_W);

`ifdef SEQGEN_PARITY_EN
   typedef enum logic [2:0] {IDLE, SHIFT, PARITY, GAP, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, SHIFT, GAP, DONE} state_t;
`endif

   state_t           state_q, state_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [PAT_W-1:0] shreg_q, shreg_d;
   logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] rep_q, rep_d;
   logic [GAP_W-1:0] gap_len_q, gap_len_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             seq_q, seq_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             frame_end;

   always_comb begin
      // NOTE: every variable written here gets a default first, so no path can infer a latch.
      state_d   = state_q;
      pat_d     = pat_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      rep_d     = rep_q;
      gap_len_d = gap_len_q;
      gap_d     = gap_q;
      frame_end = 1'b0;
      seq_d     = 1'b0;
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               pat_d     = bus.pattern_in;
               rep_d     = bus.repeat_cnt;
               gap_len_d = bus.gap_len;
               shreg_d   = bus.pattern_in;
               bit_cnt_d = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            shreg_d   = shreg_q << 1;
            bit_cnt_d = bit_cnt_q + BCW'(1);
            if (bit_cnt_q == BCW'(PAT_W - 1)) begin
`ifdef SEQGEN_PARITY_EN
               state_d = PARITY;
`else
               frame_end = 1'b1;
`endif
            end
         end
`ifdef SEQGEN_PARITY_EN
         PARITY: frame_end = 1'b1;
`endif
         GAP: begin
            if (gap_q == GAP_W'(1)) begin
               state_d   = SHIFT;
               shreg_d   = pat_q;
               bit_cnt_d = '0;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Frame boundary: the repeat counter reading 0 marks the final frame, so all-ones never wraps.
      if (frame_end) begin
         if (rep_q == '0) begin
            state_d = DONE;
         end else begin
            rep_d = rep_q - CNT_W'(1);
            if (gap_len_q != '0) begin
               state_d = GAP;
               gap_d   = gap_len_q;
            end else begin
               state_d   = SHIFT;
               shreg_d   = pat_q;
               bit_cnt_d = '0;
            end
         end
      end

      // Port values are derived from the next state and registered below.
      case (state_d)
         SHIFT: begin
            seq_d   = shreg_d[PAT_W-1];
            valid_d = 1'b1;
            busy_d  = 1'b1;
         end
`ifdef SEQGEN_PARITY_EN
         PARITY: begin
            seq_d   = ^pat_d;
            valid_d = 1'b1;
            busy_d  = 1'b1;
         end
`endif
         GAP:     busy_d = 1'b1;
         DONE:    done_d = 1'b1;
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         pat_q     <= '0;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         rep_q     <= '0;
         gap_len_q <= '0;
         gap_q     <= '0;
         seq_q     <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pat_q     <= pat_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         rep_q     <= rep_d;
         gap_len_q <= gap_len_d;
         gap_q     <= gap_d;
         seq_q     <= seq_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.sequence_out = seq_q;
   assign bus.valid_out    = valid_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
endmodule
